// File: rtl/id_ex_stage_pkg.sv
// Shared control-word definitions for the decoder and the ID/EX pipeline register.
// The packed struct fixes each field's bit position, MSB first.
package id_ex_stage_pkg;

  typedef struct packed {
    logic       reg_write;    // [15]
    logic [2:0] alu_op;       // [14:12]
    logic       alu_src;      // [11]
    logic [1:0] reg_dst;      // [10:9]
    logic       branch;       // [8]
    logic       sign;         // [7]
    logic [1:0] branch_type;  // [6:5]
    logic       jump;         // [4]
    logic       mem_read;     // [3]
    logic       mem_write;    // [2]
    logic [1:0] mem_to_reg;   // [1:0]
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
// Purely combinational; a taken flush suppresses the stall.
module hazard_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       flush_i,
  output logic       hazard_o
);

  logic rt_match;

  // $zero is never a real destination, so it cannot create a dependency
  assign rt_match = (ex_rt_i != 5'd0) && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
  assign hazard_o = ex_valid_i && ex_mem_read_i && rt_match && !flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// Optional ID_EX_PERF_CNT_EN adds saturating stall/flush event counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [15:0] id_ctrl_i,
  input  logic [31:0] id_pc4_i,
  input  logic [31:0] id_rs_data_i,
  input  logic [31:0] id_rt_data_i,
  input  logic [31:0] id_imm_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  id_rd_i,
  output logic        stall_o,
  output logic [15:0] ex_ctrl_o,
  output logic [31:0] ex_pc4_o,
  output logic [31:0] ex_rs_data_o,
  output logic [31:0] ex_rt_data_o,
  output logic [31:0] ex_imm_o,
  output logic [4:0]  ex_rs_o,
  output logic [4:0]  ex_rt_o,
  output logic [4:0]  ex_rd_o,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic        ex_valid_o
);

  ctrl_word_t  ex_ctrl_q, ex_ctrl_d;
  logic [31:0] ex_pc4_q, ex_pc4_d;
  logic [31:0] ex_rs_data_q, ex_rs_data_d;
  logic [31:0] ex_rt_data_q, ex_rt_data_d;
  logic [31:0] ex_imm_q, ex_imm_d;
  logic [4:0]  ex_rs_q, ex_rs_d;
  logic [4:0]  ex_rt_q, ex_rt_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_valid_q, ex_valid_d;
  logic        stall;

  hazard_detect u_hazard_detect (
    .ex_valid_i    (ex_valid_q),
    .ex_mem_read_i (ex_ctrl_q.mem_read),
    .ex_rt_i       (ex_rt_q),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .flush_i       (flush_i),
    .hazard_o      (stall)
  );

  // Flush and stall both produce the same all-zero bubble
  always_comb begin
    ex_ctrl_d    = CTRL_BUBBLE;
    ex_pc4_d     = '0;
    ex_rs_data_d = '0;
    ex_rt_data_d = '0;
    ex_imm_d     = '0;
    ex_rs_d      = '0;
    ex_rt_d      = '0;
    ex_rd_d      = '0;
    ex_valid_d   = 1'b0;
    if (!flush_i && !stall) begin
      ex_ctrl_d    = ctrl_word_t'(id_ctrl_i);
      ex_pc4_d     = id_pc4_i;
      ex_rs_data_d = id_rs_data_i;
      ex_rt_data_d = id_rt_data_i;
      ex_imm_d     = id_imm_i;
      ex_rs_d      = id_rs_i;
      ex_rt_d      = id_rt_i;
      ex_rd_d      = id_rd_i;
      ex_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_ctrl_q    <= CTRL_BUBBLE;
      ex_pc4_q     <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_valid_q   <= 1'b0;
    end else begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_pc4_q     <= ex_pc4_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_valid_q   <= ex_valid_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // stall is already masked by flush, so each edge bumps at most one counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush_i && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

  assign stall_o      = stall;
  assign ex_ctrl_o    = ex_ctrl_q;
  assign ex_pc4_o     = ex_pc4_q;
  assign ex_rs_data_o = ex_rs_data_q;
  assign ex_rt_data_o = ex_rt_data_q;
  assign ex_imm_o     = ex_imm_q;
  assign ex_rs_o      = ex_rs_q;
  assign ex_rt_o      = ex_rt_q;
  assign ex_rd_o      = ex_rd_q;
  assign ex_valid_o   = ex_valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a slot-level reference model.
// Define ID_EX_PERF_CNT_EN to also check the event counters.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic [15:0] id_ctrl_i;
  logic [31:0] id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic        stall_o;
  logic [15:0] ex_ctrl_o;
  logic [31:0] ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
  logic        ex_valid_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  id_ex_stage dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .id_ctrl_i    (id_ctrl_i),
    .id_pc4_i     (id_pc4_i),
    .id_rs_data_i (id_rs_data_i),
    .id_rt_data_i (id_rt_data_i),
    .id_imm_i     (id_imm_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_rd_i      (id_rd_i),
    .stall_o      (stall_o),
    .ex_ctrl_o    (ex_ctrl_o),
    .ex_pc4_o     (ex_pc4_o),
    .ex_rs_data_o (ex_rs_data_o),
    .ex_rt_data_o (ex_rt_data_o),
    .ex_imm_o     (ex_imm_o),
    .ex_rs_o      (ex_rs_o),
    .ex_rt_o      (ex_rt_o),
    .ex_rd_o      (ex_rd_o),
`ifdef ID_EX_PERF_CNT_EN
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o),
`endif
    .ex_valid_o   (ex_valid_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [15:0] LW_CTRL   = 16'hA89A;  // RegWrite, ALUSrc, MemRead set
  localparam logic [15:0] ADDI_CTRL = 16'hE180;

  // One record describing what the EX slot should contain
  typedef struct {
    bit          valid;
    logic [15:0] ctrl;
    logic [31:0] pc4, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
  } slot_t;

  slot_t       m_slot;
  logic [31:0] m_stall_cnt, m_flush_cnt;
  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  logic        obs_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.ctrl = '0; s.pc4 = '0; s.rsd = '0; s.rtd = '0;
    s.imm = '0; s.rs = '0; s.rt = '0; s.rd = '0;
    return s;
  endfunction

  // A load in EX blocks any ID instruction that reads its (nonzero) destination
  function automatic bit model_stall(input logic [4:0] s, input logic [4:0] t, input logic fl);
    bit uses_load = m_slot.valid && m_slot.ctrl[3] && (m_slot.rt != 0) &&
                    (m_slot.rt == s || m_slot.rt == t);
    return uses_load && !fl;
  endfunction

  task automatic check_outputs(input string pfx);
    check({pfx, "_valid"}, 32'(ex_valid_o), 32'(m_slot.valid));
    check({pfx, "_ctrl"},  32'(ex_ctrl_o),  32'(m_slot.ctrl));
    check({pfx, "_pc4"},   ex_pc4_o,        m_slot.pc4);
    check({pfx, "_rsd"},   ex_rs_data_o,    m_slot.rsd);
    check({pfx, "_rtd"},   ex_rt_data_o,    m_slot.rtd);
    check({pfx, "_imm"},   ex_imm_o,        m_slot.imm);
    check({pfx, "_rs"},    32'(ex_rs_o),    32'(m_slot.rs));
    check({pfx, "_rt"},    32'(ex_rt_o),    32'(m_slot.rt));
    check({pfx, "_rd"},    32'(ex_rd_o),    32'(m_slot.rd));
`ifdef ID_EX_PERF_CNT_EN
    check({pfx, "_scnt"},  stall_cnt_o,     m_stall_cnt);
    check({pfx, "_fcnt"},  flush_cnt_o,     m_flush_cnt);
`endif
  endtask

  task automatic do_cycle(input logic fl, input logic [15:0] c, input logic [31:0] p,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                          input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    bit exp_st;
    @(negedge clk_i);
    flush_i = fl; id_ctrl_i = c; id_pc4_i = p; id_rs_data_i = a; id_rt_data_i = b;
    id_imm_i = im; id_rs_i = s; id_rt_i = t; id_rd_i = d;
    #1;
    exp_st    = model_stall(s, t, fl);
    obs_stall = stall_o;
    check("stall", 32'(stall_o), 32'(exp_st));
    @(posedge clk_i);
    if (fl) begin
      m_slot = empty_slot();
      if (m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    end else if (exp_st) begin
      m_slot = empty_slot();
      if (m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    end else begin
      m_slot.valid = 1; m_slot.ctrl = c; m_slot.pc4 = p; m_slot.rsd = a;
      m_slot.rtd = b; m_slot.imm = im; m_slot.rs = s; m_slot.rt = t; m_slot.rd = d;
    end
    #1;
    check_outputs("q");
  endtask

  // Drop reset between edges and verify the outputs clear without a clock
  task automatic async_reset();
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    m_slot = empty_slot();
    m_stall_cnt = '0;
    m_flush_cnt = '0;
    check_outputs("rst");
    check("rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    logic [15:0] rc;
    rst_i = 1'b0; flush_i = 0; id_ctrl_i = '0; id_pc4_i = '0; id_rs_data_i = '0;
    id_rt_data_i = '0; id_imm_i = '0; id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
    m_slot = empty_slot(); m_stall_cnt = '0; m_flush_cnt = '0;
    #2;
    check_outputs("init");
    @(negedge clk_i);
    rst_i = 1'b1;

    // addi-like pass-through
    do_cycle(0, ADDI_CTRL, 32'h104, 32'h11, 32'h22, 32'h5, 5'd1, 5'd2, 5'd3);
    check("pass_ctrl", 32'(ex_ctrl_o), 32'h0000_E180);
    check("pass_imm", ex_imm_o, 32'h5);
    check("pass_valid", 32'(ex_valid_o), 32'd1);

    // load-use on rs: one stall, one bubble, then capture
    do_cycle(0, LW_CTRL, 32'h108, 32'h0, 32'h0, 32'h4, 5'd9, 5'd8, 5'd0);
    do_cycle(0, ADDI_CTRL, 32'h10C, 32'hAA, 32'hBB, 32'h7, 5'd8, 5'd4, 5'd5);
    check("lu_stall", 32'(obs_stall), 32'd1);
    check("lu_bubble", 32'(ex_valid_o), 32'd0);
    do_cycle(0, ADDI_CTRL, 32'h10C, 32'hAA, 32'hBB, 32'h7, 5'd8, 5'd4, 5'd5);
    check("lu_release", 32'(obs_stall), 32'd0);
    check("lu_capture_pc", ex_pc4_o, 32'h10C);

    // load to $zero never stalls
    do_cycle(0, LW_CTRL, 32'h110, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0);
    do_cycle(0, ADDI_CTRL, 32'h114, 32'h1, 32'h2, 32'h3, 5'd0, 5'd0, 5'd6);
    check("zero_stall", 32'(obs_stall), 32'd0);
    check("zero_valid", 32'(ex_valid_o), 32'd1);

    // flush concurrent with a hazard wins
    do_cycle(0, LW_CTRL, 32'h118, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0);
    do_cycle(1, ADDI_CTRL, 32'h11C, 32'h1, 32'h2, 32'h3, 5'd8, 5'd4, 5'd6);
    check("fl_stall", 32'(obs_stall), 32'd0);
    check("fl_bubble", 32'(ex_valid_o), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    check("fl_fcnt", flush_cnt_o, 32'd1);
    check("fl_scnt", stall_cnt_o, 32'd1);

    // saturation of the stall counter
    @(negedge clk_i);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    m_stall_cnt = 32'hFFFF_FFFF;
    do_cycle(0, LW_CTRL, 32'h120, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0);
    do_cycle(0, ADDI_CTRL, 32'h124, 32'h1, 32'h2, 32'h3, 5'd8, 5'd4, 5'd6);
    check("sat_scnt", stall_cnt_o, 32'hFFFF_FFFF);
`endif

    // reset while a valid instruction sits in EX
    async_reset();

    for (int i = 0; i < 400; i++) begin
      rc = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rc[3] = 1'b1;
      if ($urandom_range(0, 59) == 0) async_reset();
      else
        do_cycle(($urandom_range(0, 4) == 0), rc, $urandom, $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have exactly one clock and one reset; the reset is asynchronous and active-low.
REQ-002 clk_i  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 flush_i  input  1  branch/jump taken in EX; squashes the instruction now in ID.
REQ-005 id_ctrl_i  input  16  packed decoder control word: {RegWrite, ALU_op[2:0], ALUSrc, RegDst[1:0], Branch, sign, BranchType[1:0], Jump, MemRead, MemWrite, MemtoReg[1:0]}, MSB first.
REQ-006 id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i  input  32 each  PC+4, register-file read data, sign/zero-extended immediate.
REQ-007 id_rs_i, id_rt_i, id_rd_i  input  5 each  register fields of the ID instruction.
REQ-008 stall_o  output  1  combinational load-use hazard; holds PC and IF/ID when 1.
REQ-009 ex_ctrl_o  output  16; ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o  output  32 each; ex_rs_o, ex_rt_o, ex_rd_o  output  5 each  registered copies for EX.
REQ-010 ex_valid_o  output  1  EX slot holds a real instruction (0 = bubble).

Function
REQ-011 Hazard: stall_o SHALL be 1 iff ex_valid_o=1, ex_ctrl_o.MemRead=1, ex_rt_o!=0, (ex_rt_o==id_rs_i or ex_rt_o==id_rt_i), and flush_i=0.
REQ-012 Update priority at each rising edge: flush_i=1 -> bubble; else stall_o=1 -> bubble; else capture all id_* inputs and set ex_valid_o=1.
REQ-013 Bubble: ex_ctrl_o=0, ex_valid_o=0, all datapath/field outputs=0.
REQ-014 Latency: ID inputs appear on ex_* exactly one cycle after capture; no other buffering.
REQ-015 A load-use stall SHALL last exactly one cycle (the inserted bubble clears ex_valid_o, so the hazard deasserts).
REQ-016 flush_i concurrent with a hazard: flush wins, stall_o=0, bubble inserted.
REQ-017 rs/rt equal to register 0 never raises a hazard.
REQ-018 Outputs SHALL NOT depend combinationally on id_* except stall_o.

Reset
REQ-019 While rst_i=0 all registered outputs SHALL be 0 (ex_valid_o=0, ex_ctrl_o=0), asynchronously.
REQ-020 First capture occurs on the first rising edge with rst_i=1; reset mid-stall or mid-flush discards the pending instruction.

Configuration
REQ-021 Macro ID_EX_PERF_CNT_EN: when defined, adds outputs stall_cnt_o and flush_cnt_o (32 bits each), each incrementing by 1 on every edge where the corresponding bubble cause is taken (flush counted before stall per REQ-012), saturating at 0xFFFFFFFF, reset to 0.
REQ-022 When ID_EX_PERF_CNT_EN is undefined, the counters and ports SHALL not exist; all other behaviour identical.

Structure
REQ-023 A shared package SHALL hold the 16-bit control-word typedef, its field bit positions, and the all-zero bubble constant; the decoder and EX stage use the same package.
REQ-024 Sub-module hazard_detect (pure combinational, REQ-011/REQ-017) SHALL be instantiated inside id_ex_stage; the pipeline register stays in the top.

Verification
REQ-025 Reset: assert rst_i=0 mid-cycle with ex_valid_o=1 -> all outputs 0 immediately, no clock needed.
REQ-026 Pass-through: id_ctrl_i=16'hE180 (addi-like), id_imm_i=32'h0000_0005, no hazard -> next edge ex_ctrl_o=16'hE180, ex_imm_o=5, ex_valid_o=1.
REQ-027 Load-use: EX holds lw (MemRead=1) with ex_rt_o=8, ID has id_rs_i=8 -> stall_o=1 for one cycle, next edge ex_valid_o=0, following cycle stall_o=0 and the ID instruction is captured.
REQ-028 $zero: EX lw with ex_rt_o=0, ID id_rs_i=0 -> stall_o=0, capture proceeds.
REQ-029 Flush vs stall: hazard conditions of REQ-027 plus flush_i=1 -> stall_o=0, next edge bubble; with ID_EX_PERF_CNT_EN, flush_cnt_o +1, stall_cnt_o unchanged.
REQ-030 Counter saturation (ID_EX_PERF_CNT_EN): force stall_cnt_o to 0xFFFFFFFF, trigger another stall -> stays 0xFFFFFFFF.
